// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives the PC into a combinational-read instruction
// memory, buffers fetched words in a small prefetch FIFO, and handles redirect, stall and halt.
module fetch_ctrl #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    mem_pc,
  output logic               mem_en,
  input  logic [INSTR_W-1:0] mem_instr,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               out_ready,
  output logic [1:0]         dbg_state_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_STALL  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ins_mem_q [DEPTH];
  logic [PC_W-1:0]     pcs_mem_q [DEPTH];
  logic                push, pop;

  // Handshake: the head transfers on any cycle where out_valid and out_ready are both high.
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid & out_ready;
  assign push        = mem_en;
  assign mem_pc      = pc_q;
  assign out_instr   = out_valid ? ins_mem_q[rd_q] : '0;
  assign out_pc      = out_valid ? pcs_mem_q[rd_q] : '0;
  assign dbg_state_o = state_q;

  always_comb begin
    mem_en = (state_q == S_FETCH) && !redirect && !halt && !reset &&
             ((count_q < FULL) || pop);
  end

  always_comb begin
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect) begin
      // Flush drops every entry, including one popped in this same cycle.
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
      pc_d    = redirect_pc;
      state_d = halt ? S_HALTED : S_FETCH;
    end else begin
      if (push) begin
        wr_d = wr_q + AW'(1);
        pc_d = pc_q + PC_W'(1);
      end
      if (pop) rd_d = rd_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (halt) begin
        state_d = S_HALTED;
      end else begin
        case (state_q)
          S_FETCH:  if (count_d == FULL && !pop) state_d = S_STALL;
          S_STALL:  if (pop) state_d = S_FETCH;
          S_HALTED: state_d = S_FETCH;
          default:  state_d = S_FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      pc_q    <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        ins_mem_q[i] <= '0;
        pcs_mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
      if (push) begin
        ins_mem_q[wr_q] <= mem_instr;
        pcs_mem_q[wr_q] <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; the instruction memory returns 16'hA000 + address.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_pc;
  logic        mem_en;
  logic [15:0] mem_instr;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        out_ready = 1'b0;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  localparam logic [1:0] ST_FETCH = 2'd0, ST_STALL = 2'd1, ST_HALTED = 2'd2;

  always #5 clk = ~clk;

  assign mem_instr = 16'hA000 + mem_pc;

  fetch_ctrl #(.PC_W(16), .INSTR_W(16), .DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .mem_pc(mem_pc), .mem_en(mem_en), .mem_instr(mem_instr),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .dbg_state_o(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; halt = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (out_pc !== 16'h0000) begin failures++; $display("FAIL rst_out_pc got=%h exp=0000", out_pc); end
    checks++; if (out_instr !== 16'h0000) begin failures++; $display("FAIL rst_out_instr got=%h exp=0000", out_instr); end
    checks++; if (mem_pc !== 16'h0000) begin failures++; $display("FAIL rst_mem_pc got=%h exp=0000", mem_pc); end
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
    checks++; if (dbg_state !== ST_FETCH) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    reset = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL stream_en0 got=%b exp=1", mem_en); end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, out_valid); end
      checks++; if (out_pc !== 16'(k)) begin failures++; $display("FAIL stream_pc got=%h exp=%h", out_pc, 16'(k)); end
      checks++; if (out_instr !== 16'hA000 + 16'(k)) begin failures++; $display("FAIL stream_instr got=%h exp=%h", out_instr, 16'hA000 + 16'(k)); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    tick();
    checks++; if (dbg_state !== ST_STALL) begin failures++; $display("FAIL stall_state got=%0d exp=1", dbg_state); end
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL stall_en got=%b exp=0", mem_en); end
    checks++; if (mem_pc !== 16'h0002) begin failures++; $display("FAIL stall_mem_pc got=%h exp=0002", mem_pc); end
    checks++; if (out_pc !== 16'h0000) begin failures++; $display("FAIL stall_head got=%h exp=0000", out_pc); end
    out_ready = 1'b1;
    #1;
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL stall_pop_en got=%b exp=0", mem_en); end
    tick();
    checks++; if (out_pc !== 16'h0001) begin failures++; $display("FAIL stall_out1 got=%h exp=0001", out_pc); end
    checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL stall_resume_en got=%b exp=1", mem_en); end
    tick();
    checks++; if (out_pc !== 16'h0002) begin failures++; $display("FAIL stall_out2 got=%h exp=0002", out_pc); end
    checks++; if (out_instr !== 16'hA002) begin failures++; $display("FAIL stall_instr2 got=%h exp=A002", out_instr); end
  endtask

  // Leaves the FIFO full in FETCH with out_ready high: entries 2,3 queued, mem_pc=4.
  task automatic test_full_pushpop();
    do_reset();
    tick();
    tick();
    halt = 1'b1;
    tick();
    checks++; if (dbg_state !== ST_HALTED) begin failures++; $display("FAIL full_halted got=%0d exp=2", dbg_state); end
    halt = 1'b0;
    tick();
    out_ready = 1'b1;
    #1;
    checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL full_en got=%b exp=1", mem_en); end
    checks++; if (mem_pc !== 16'h0002) begin failures++; $display("FAIL full_mem_pc0 got=%h exp=0002", mem_pc); end
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++; if (mem_pc !== 16'(k + 2)) begin failures++; $display("FAIL full_mem_pc got=%h exp=%h", mem_pc, 16'(k + 2)); end
      checks++; if (out_pc !== 16'(k)) begin failures++; $display("FAIL full_head got=%h exp=%h", out_pc, 16'(k)); end
      checks++; if (dbg_state !== ST_FETCH) begin failures++; $display("FAIL full_state got=%0d exp=0", dbg_state); end
    end
  endtask

  task automatic test_redirect();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL redir_en got=%b exp=0", mem_en); end
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b exp=0", out_valid); end
    checks++; if (out_pc !== 16'h0000) begin failures++; $display("FAIL redir_flush_pc got=%h exp=0000", out_pc); end
    checks++; if (mem_pc !== 16'h0040) begin failures++; $display("FAIL redir_mem_pc got=%h exp=0040", mem_pc); end
    tick();
    checks++; if (out_pc !== 16'h0040) begin failures++; $display("FAIL redir_out_pc got=%h exp=0040", out_pc); end
    checks++; if (out_instr !== 16'hA040) begin failures++; $display("FAIL redir_out_instr got=%h exp=A040", out_instr); end
    tick();
    checks++; if (out_pc !== 16'h0041) begin failures++; $display("FAIL redir_next got=%h exp=0041", out_pc); end
  endtask

  task automatic test_halt();
    out_ready = 1'b0;
    halt = 1'b1;
    #1;
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL halt_en_c1 got=%b exp=0", mem_en); end
    tick();
    out_ready = 1'b1;
    #1;
    checks++; if (out_pc !== 16'h0041) begin failures++; $display("FAIL halt_drain_head got=%h exp=0041", out_pc); end
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL halt_en_c2 got=%b exp=0", mem_en); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL halt_drained got=%b exp=0", out_valid); end
    checks++; if (mem_pc !== 16'h0042) begin failures++; $display("FAIL halt_held_pc got=%h exp=0042", mem_pc); end
    redirect = 1'b1;
    redirect_pc = 16'h0080;
    #1;
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL halt_redir_en got=%b exp=0", mem_en); end
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (mem_pc !== 16'h0080) begin failures++; $display("FAIL halt_redir_pc got=%h exp=0080", mem_pc); end
    checks++; if (dbg_state !== ST_HALTED) begin failures++; $display("FAIL halt_redir_state got=%0d exp=2", dbg_state); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL halt_redir_valid got=%b exp=0", out_valid); end
    tick();
    halt = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL halt_release_en got=%b exp=0", mem_en); end
    tick();
    checks++; if (mem_en !== 1'b1) begin failures++; $display("FAIL halt_resume_en got=%b exp=1", mem_en); end
    checks++; if (mem_pc !== 16'h0080) begin failures++; $display("FAIL halt_resume_pc got=%h exp=0080", mem_pc); end
    tick();
    checks++; if (out_pc !== 16'h0080) begin failures++; $display("FAIL halt_out_pc got=%h exp=0080", out_pc); end
    checks++; if (out_instr !== 16'hA080) begin failures++; $display("FAIL halt_out_instr got=%h exp=A080", out_instr); end
  endtask

  task automatic test_wrap_and_reset();
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (mem_pc !== 16'hFFFF) begin failures++; $display("FAIL wrap_mem_pc got=%h exp=FFFF", mem_pc); end
    tick();
    checks++; if (out_pc !== 16'hFFFF) begin failures++; $display("FAIL wrap_out_ffff got=%h exp=FFFF", out_pc); end
    checks++; if (out_instr !== 16'h9FFF) begin failures++; $display("FAIL wrap_instr_ffff got=%h exp=9FFF", out_instr); end
    checks++; if (mem_pc !== 16'h0000) begin failures++; $display("FAIL wrap_mem_pc0 got=%h exp=0000", mem_pc); end
    tick();
    checks++; if (out_pc !== 16'h0000) begin failures++; $display("FAIL wrap_out_0 got=%h exp=0000", out_pc); end
    checks++; if (out_instr !== 16'hA000) begin failures++; $display("FAIL wrap_instr_0 got=%h exp=A000", out_instr); end
    tick();
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    checks++; if (out_instr !== 16'h0000) begin failures++; $display("FAIL midrst_instr got=%h exp=0000", out_instr); end
    checks++; if (out_pc !== 16'h0000) begin failures++; $display("FAIL midrst_out_pc got=%h exp=0000", out_pc); end
    checks++; if (mem_pc !== 16'h0000) begin failures++; $display("FAIL midrst_mem_pc got=%h exp=0000", mem_pc); end
    checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL midrst_en got=%b exp=0", mem_en); end
    tick();
    checks++; if (mem_pc !== 16'h0000) begin failures++; $display("FAIL midrst_hold_pc got=%h exp=0000", mem_pc); end
    reset = 1'b0;
    #1;
    tick();
    checks++; if (out_pc !== 16'h0000) begin failures++; $display("FAIL postrst_pc got=%h exp=0000", out_pc); end
    checks++; if (out_instr !== 16'hA000) begin failures++; $display("FAIL postrst_instr got=%h exp=A000", out_instr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_full_pushpop();
    test_redirect();
    test_halt();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
